clk_gate_ctrl: RTL and testbench

Controls the enable of a shared clock-gate cell (CLK_EN drives the gate's enable input) for a gated domain such as the ALU. Multiple requesters ask for the gated clock. The controller opens the gate, waits a fixed wake-up settle time, and then grants. After the last request drops it keeps the clock alive for an idle window before gating off. A saturating counter of gated-off cycles is kept for power accounting.

---
 rtl/clk_gate_ctrl.sv | 131 +++++++++++++
 tb/tb_clk_gate_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: opens the shared gate on request, waits a settle time,
// grants all active requesters together, and holds the clock for an idle window before closing.
//
// state  | meaning
// S_OFF  | gate closed, waiting for any request
// S_WAKE | gate open, settle time running, no grants yet
// S_ON   | clock stable, grants follow requests one cycle late
// S_HOLD | no requests, idle window running before the gate closes
module clk_gate_ctrl #(
   parameter int NUM_REQ     = 2,
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               test_en_i,
   input  logic               cnt_clr_i,
   output logic               clk_en_o,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               busy_o,
   output logic [CNT_W-1:0]   off_cnt_o
);

   localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_HOLD} state_e;

   state_e               state_q, state_d;
   logic [WAKE_W-1:0]    wake_cnt_q, wake_cnt_d;
   logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [CNT_W-1:0]     off_cnt_q, off_cnt_d;
   logic                 any_req;
   logic                 en_reg;
   logic                 clk_en;

   assign any_req = |req_i;
   assign en_reg  = (state_q != S_OFF);
   assign clk_en  = en_reg | test_en_i;

   always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;
      gnt_d      = gnt_q;
      unique case (state_q)
         S_OFF: begin
            gnt_d = '0;
            if (any_req) begin
               state_d    = S_WAKE;
               wake_cnt_d = WAKE_LOAD;
            end
         end
         // Settle always completes even if the request has gone away meanwhile.
         S_WAKE: begin
            gnt_d = '0;
            if (wake_cnt_q == '0) begin
               state_d = S_ON;
               gnt_d   = req_i;
            end else begin
               wake_cnt_d = wake_cnt_q - WAKE_W'(1);
            end
         end
         S_ON: begin
            if (any_req) begin
               gnt_d = req_i;
            end else begin
               gnt_d = '0;
               if (IDLE_CYCLES > 0) begin
                  state_d    = S_HOLD;
                  idle_cnt_d = IDLE_LOAD;
               end else begin
                  state_d = S_OFF;
               end
            end
         end
         S_HOLD: begin
            gnt_d = '0;
            if (any_req) begin
               state_d = S_ON;
               gnt_d   = req_i;
            end else if (idle_cnt_q == '0) begin
               state_d = S_OFF;
            end else begin
               idle_cnt_d = idle_cnt_q - IDLE_W'(1);
            end
         end
         default: begin
            state_d = S_OFF;
            gnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      off_cnt_d = off_cnt_q;
      if (cnt_clr_i) begin
         off_cnt_d = '0;
      end else if (!clk_en && (off_cnt_q != CNT_MAX)) begin
         off_cnt_d = off_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_OFF;
         wake_cnt_q <= '0;
         idle_cnt_q <= '0;
         gnt_q      <= '0;
         off_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         wake_cnt_q <= wake_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         gnt_q      <= gnt_d;
         off_cnt_q  <= off_cnt_d;
      end
   end

   assign clk_en_o  = clk_en;
   assign gnt_o     = gnt_q;
   assign busy_o    = en_reg;
   assign off_cnt_o = off_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: expected {clk_en, busy, gnt, off_cnt} vectors are queued
// when stimulus is applied and checked after the following clock edge.
module tb_clk_gate_ctrl;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic        test_en;
   logic        cnt_clr;
   logic        clk_en;
   logic [1:0]  gnt;
   logic        busy;
   logic [15:0] off_cnt;

   typedef struct {
      string       tag;
      logic [19:0] exp;
   } sb_entry_t;

   sb_entry_t   sb[$];
   int          total = 0;
   int          bad   = 0;
   logic        fsm_en = 1'b0;
   logic [15:0] exp_cnt = 16'd0;

   clk_gate_ctrl #(
      .NUM_REQ    (2),
      .WAKE_CYCLES(2),
      .IDLE_CYCLES(4),
      .CNT_W      (16)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req),
      .test_en_i(test_en),
      .cnt_clr_i(cnt_clr),
      .clk_en_o (clk_en),
      .gnt_o    (gnt),
      .busy_o   (busy),
      .off_cnt_o(off_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic en_fsm, input logic [1:0] g);
      sb_entry_t e;
      e.tag = tag;
      e.exp = {en_fsm | test_en, en_fsm, g, exp_cnt};
      sb.push_back(e);
   endtask

   task automatic pop_check();
      sb_entry_t   e;
      logic [19:0] obs;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty: observed=empty expected=entry");
      end else begin
         e   = sb.pop_front();
         obs = {clk_en, busy, gnt, off_cnt};
         assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s: observed en/busy/gnt/cnt=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   // One clock edge: expected counter moves on the pre-edge CLK_EN, FSM enable as given.
   task automatic tick(input string tag, input logic en_after, input logic [1:0] g_after);
      if (cnt_clr) exp_cnt = 16'd0;
      else if (!(fsm_en | test_en) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      fsm_en = en_after;
      push(tag, en_after, g_after);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic check_now(input string tag);
      push(tag, fsm_en, (fsm_en ? gnt : 2'b00));
      #1;
      pop_check();
   endtask

   initial begin
      rst_n = 1'b0; req = 2'b00; test_en = 1'b0; cnt_clr = 1'b0;
      #12;
      push("reset", 1'b0, 2'b00);
      #1;
      pop_check();
      rst_n = 1'b1;

      // Gate closed: counter runs every edge.
      for (int i = 0; i < 10; i++) tick("off_count", 1'b0, 2'b00);

      // Wake: enable right away, grant after two edges.
      req = 2'b01;
      tick("wake_en", 1'b1, 2'b00);
      tick("wake_nogrant", 1'b1, 2'b00);
      tick("grant01", 1'b1, 2'b01);
      tick("on_hold01", 1'b1, 2'b01);

      // Idle window: enable held four edges, closes on the fifth.
      req = 2'b00;
      for (int i = 0; i < 4; i++) tick("idle_hold", 1'b1, 2'b00);
      tick("gate_closed", 1'b0, 2'b00);
      tick("off_again", 1'b0, 2'b00);

      // Request in HOLD with idle_cnt==1 regrants without wake.
      req = 2'b10;
      tick("wake2_a", 1'b1, 2'b00);
      tick("wake2_b", 1'b1, 2'b00);
      tick("grant10", 1'b1, 2'b10);
      req = 2'b00;
      for (int i = 0; i < 3; i++) tick("hold_to_idle1", 1'b1, 2'b00);
      req = 2'b10;
      tick("hold_regrant10", 1'b1, 2'b10);

      // Request on the last HOLD cycle (idle_cnt==0) still keeps the gate open.
      req = 2'b00;
      for (int i = 0; i < 4; i++) tick("hold_to_idle0", 1'b1, 2'b00);
      req = 2'b01;
      tick("hold_last_regrant", 1'b1, 2'b01);

      // Close, then simultaneous requests and a partial drop.
      req = 2'b00;
      for (int i = 0; i < 4; i++) tick("idle_hold2", 1'b1, 2'b00);
      tick("gate_closed2", 1'b0, 2'b00);
      req = 2'b11;
      tick("wake3_a", 1'b1, 2'b00);
      tick("wake3_b", 1'b1, 2'b00);
      tick("grant11", 1'b1, 2'b11);
      req = 2'b10;
      tick("drop_req0", 1'b1, 2'b10);
      tick("stay_on10", 1'b1, 2'b10);

      // Back to OFF, then test enable forces the gate and freezes the counter.
      req = 2'b00;
      for (int i = 0; i < 4; i++) tick("idle_hold3", 1'b1, 2'b00);
      tick("gate_closed3", 1'b0, 2'b00);
      test_en = 1'b1;
      check_now("test_en_force");
      for (int i = 0; i < 3; i++) tick("test_en_frozen", 1'b0, 2'b00);
      req = 2'b01;
      tick("test_wake_a", 1'b1, 2'b00);
      tick("test_wake_b", 1'b1, 2'b00);
      tick("test_grant01", 1'b1, 2'b01);
      test_en = 1'b0;
      tick("on_no_test", 1'b1, 2'b01);

      // Asynchronous reset in ON.
      #3;
      rst_n = 1'b0;
      fsm_en = 1'b0;
      exp_cnt = 16'd0;
      check_now("async_reset_on");
      test_en = 1'b1;
      check_now("reset_test_en_holds");
      test_en = 1'b0;
      req = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = 16'd1;
      fsm_en = 1'b0;
      check_now("after_reset_count");

      // Saturation and clear.
      for (int i = 0; i < 65540; i++) tick("saturate", 1'b0, 2'b00);
      tick("stay_ffff", 1'b0, 2'b00);
      cnt_clr = 1'b1;
      tick("cnt_clear", 1'b0, 2'b00);
      cnt_clr = 1'b0;
      tick("count_after_clear", 1'b0, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
